// File: rtl/aes_pkg.sv
// Shared AES definitions for the key scheduler: key-length encodings, FSM
// states, Nk/Nr lookups, the GF(2^8) xtime helper and width constants.
package aes_pkg;

    // keyLen port encoding
    typedef enum logic [1:0] {
        KEY_LEN_128     = 2'b00,
        KEY_LEN_192     = 2'b01,
        KEY_LEN_256     = 2'b10,
        KEY_LEN_ILLEGAL = 2'b11
    } key_len_e;

    // Scheduler control states
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_e;

    localparam logic [7:0] RCON_INIT   = 8'h01;
    localparam int         ROUND_KEY_W = 128;
    localparam int         WORD_W      = 32;

    // Key length in 32-bit words; 0 flags an illegal encoding
    function automatic logic [3:0] nk_of(input key_len_e len);
        case (len)
            KEY_LEN_128: return 4'd4;
            KEY_LEN_192: return 4'd6;
            KEY_LEN_256: return 4'd8;
            default:     return 4'd0;
        endcase
    endfunction

    // Round count for a key length (Nk + 6); 0 for an illegal encoding
    function automatic logic [3:0] nr_of(input key_len_e len);
        logic [3:0] nk;
        nk = nk_of(len);
        return (nk == 4'd0) ? 4'd0 : 4'(nk + 4'd6);
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform. Purely combinational, one byte in, one byte out.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // x^254 is the inverse of x in GF(2^8), and maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] pw;
        logic [7:0] acc;
        pw  = x;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            pw  = gf_mul(pw, pw);
            acc = gf_mul(acc, pw);
        end
        return acc;
    endfunction

    logic [7:0] inv;

    // Inverse then affine map with constant 0x63
    always_comb begin
        inv      = gf_inv(in_byte);
        out_byte = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128/192/256 key scheduler. Produces one 32-bit schedule word
// per clock through four shared S-boxes and keeps the complete schedule in a
// word file, read combinationally by round index once keyValid is high.
// Optional build macro AES_KEY_ZEROIZE_EN adds a zeroize input that wipes the
// word file and invalidates the schedule in a single edge.
module aes_key_schedule_seq
    import aes_pkg::*;
#(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              keyLen,
    input  logic [MAX_KEY_BITS-1:0] keyIn,
`ifdef AES_KEY_ZEROIZE_EN
    input  logic                    zeroize,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    keyValid,
    output logic                    error,
    output logic [3:0]              numRounds,
    input  logic [3:0]              rdRound,
    output logic [ROUND_KEY_W-1:0]  rdKey
);

    localparam int MAX_NK    = MAX_KEY_BITS / WORD_W;
    localparam int MAX_NR    = MAX_NK + 6;
    localparam int NUM_WORDS = 4 * (MAX_NR + 1);
    // 44..60 words always fit a 6-bit index, which equals {round, word-in-round}
    localparam int IDX_W     = 6;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        i_q, i_d;           // next word to generate
    logic [3:0]              j_q, j_d;           // i mod Nk, tracked incrementally
    logic [3:0]              nk_q, nk_d;
    logic [3:0]              nr_q, nr_d;
    logic [7:0]              rcon_q, rcon_d;
    logic                    done_q, done_d;
    logic                    key_valid_q, key_valid_d;
    logic                    error_q, error_d;
    logic [3:0]              num_rounds_q, num_rounds_d;
    logic [WORD_W-1:0]       word_q [NUM_WORDS];
    logic [WORD_W-1:0]       word_d [NUM_WORDS];

    key_len_e                len_in;
    logic [3:0]              nk_in;
    logic                    len_legal;
    logic [IDX_W-1:0]        last_idx;
    logic [WORD_W-1:0]       prev_word;
    logic [WORD_W-1:0]       old_word;
    logic [WORD_W-1:0]       sub_in;
    logic [WORD_W-1:0]       sub_out;
    logic [WORD_W-1:0]       t_word;

    // Four byte-wise S-boxes form the shared SubWord stage
    for (genvar b = 0; b < 4; b++) begin : g_sub_word
        aes_sbox u_sbox (
            .in_byte  (sub_in[8*b +: 8]),
            .out_byte (sub_out[8*b +: 8])
        );
    end

    // Decode the requested key length and its legality for this build
    always_comb begin
        len_in    = key_len_e'(keyLen);
        nk_in     = nk_of(len_in);
        len_legal = (nk_in != 4'd0) && ((int'(nk_in) * WORD_W) <= MAX_KEY_BITS);
        last_idx  = {nr_q, 2'b11};
    end

    // Derive the mixing term t for word i from w[i-1], w[i-Nk] and rcon
    always_comb begin
        prev_word = word_q[i_q - 6'd1];
        old_word  = word_q[i_q - {2'b00, nk_q}];
        sub_in    = (j_q == 4'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
        if (j_q == 4'd0) begin
            t_word = sub_out ^ {rcon_q, 24'h000000};
        end else if ((nk_q == 4'd8) && (j_q == 4'd4)) begin
            t_word = sub_out;
        end else begin
            t_word = prev_word;
        end
    end

    // Next-state, counters, flags and word-file updates
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can leave one unassigned and infer a latch.
        state_d      = state_q;
        i_d          = i_q;
        j_d          = j_q;
        nk_d         = nk_q;
        nr_d         = nr_q;
        rcon_d       = rcon_q;
        done_d       = 1'b0;
        key_valid_d  = key_valid_q;
        error_d      = error_q;
        num_rounds_d = num_rounds_q;
        word_d       = word_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_valid_d  = 1'b0;
                    num_rounds_d = 4'd0;
                    if (len_legal) begin
                        for (int k = 0; k < MAX_NK; k++) begin
                            if (k < int'(nk_in)) begin
                                word_d[k] = keyIn[MAX_KEY_BITS-1-WORD_W*k -: WORD_W];
                            end
                        end
                        nk_d    = nk_in;
                        nr_d    = nr_of(len_in);
                        i_d     = {2'b00, nk_in};
                        j_d     = 4'd0;
                        rcon_d  = RCON_INIT;
                        error_d = 1'b0;
                        state_d = ST_EXPAND;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_EXPAND: begin
                word_d[i_q] = old_word ^ t_word;
                i_d         = i_q + 6'd1;
                j_d         = (j_q == nk_q - 4'd1) ? 4'd0 : j_q + 4'd1;
                if (j_q == 4'd0) begin
                    rcon_d = xtime(rcon_q);
                end
                if (i_q == last_idx) begin
                    state_d      = ST_IDLE;
                    done_d       = 1'b1;
                    key_valid_d  = 1'b1;
                    num_rounds_d = nr_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef AES_KEY_ZEROIZE_EN
        if (zeroize) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                word_d[k] = '0;
            end
            key_valid_d  = 1'b0;
            num_rounds_d = 4'd0;
            done_d       = 1'b0;
            state_d      = ST_IDLE;
        end
`endif
    end

    // Control and status registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q      <= ST_IDLE;
            i_q          <= '0;
            j_q          <= '0;
            nk_q         <= '0;
            nr_q         <= '0;
            rcon_q       <= RCON_INIT;
            done_q       <= 1'b0;
            key_valid_q  <= 1'b0;
            error_q      <= 1'b0;
            num_rounds_q <= '0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            j_q          <= j_d;
            nk_q         <= nk_d;
            nr_q         <= nr_d;
            rcon_q       <= rcon_d;
            done_q       <= done_d;
            key_valid_q  <= key_valid_d;
            error_q      <= error_d;
            num_rounds_q <= num_rounds_d;
        end
    end

    // Schedule word file
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; keyValid gates every read, so stale words are never visible.
        word_q <= word_d;
    end

    // Round-key read port: four consecutive words, w[4r] in the MSBs
    always_comb begin
        rdKey = '0;
        if (key_valid_q && (rdRound <= num_rounds_q)) begin
            rdKey = {word_q[{rdRound, 2'b00}], word_q[{rdRound, 2'b01}],
                     word_q[{rdRound, 2'b10}], word_q[{rdRound, 2'b11}]};
        end
    end

    assign busy      = (state_q == ST_EXPAND);
    assign done      = done_q;
    assign keyValid  = key_valid_q;
    assign error     = error_q;
    assign numRounds = num_rounds_q;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Self-checking bench for aes_key_schedule_seq: FIPS-197 vectors, random keys
// against a reference expansion, illegal length, ignored restart, mid-run
// reset and (with AES_KEY_ZEROIZE_EN) zeroize behaviour.
module tb_aes_key_schedule_seq;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   keyLen;
    logic [255:0] keyIn;
    logic         busy;
    logic         done;
    logic         keyValid;
    logic         error;
    logic [3:0]   numRounds;
    logic [3:0]   rdRound;
    logic [127:0] rdKey;
`ifdef AES_KEY_ZEROIZE_EN
    logic         zeroize;
`endif

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0]  sbox_tab [256];
    logic [31:0] mw [60];

    aes_key_schedule_seq #(.MAX_KEY_BITS(256)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .keyLen    (keyLen),
        .keyIn     (keyIn),
`ifdef AES_KEY_ZEROIZE_EN
        .zeroize   (zeroize),
`endif
        .busy      (busy),
        .done      (done),
        .keyValid  (keyValid),
        .error     (error),
        .numRounds (numRounds),
        .rdRound   (rdRound),
        .rdKey     (rdKey)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box table generated by walking the multiplicative group with generator 3
    function automatic void build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_tab[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_tab[0] = 8'h63;
    endfunction

    function automatic logic [31:0] sub_w(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    // Textbook key expansion into mw[]
    function automatic void model_expand(input int nk, input logic [255:0] key);
        int          nr;
        int          rc;
        logic [31:0] t;
        nr = nk + 6;
        rc = 1;
        for (int i = 0; i < 60; i++) mw[i] = 32'h0;
        for (int i = 0; i < nk; i++) mw[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = mw[i-1];
            if (i % nk == 0) begin
                t  = sub_w({t[23:0], t[31:24]}) ^ {rc[7:0], 24'h0};
                rc = rc * 2;
                if (rc > 255) rc = rc ^ 'h11b;
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_w(t);
            end
            mw[i] = mw[i-nk] ^ t;
        end
    endfunction

    task automatic do_start(input logic [1:0] len, input logic [255:0] key);
        @(negedge clk);
        keyLen = len;
        keyIn  = key;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic check_rounds(input string tag, input int nr);
        logic [127:0] exp;
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            rdRound = 4'(r);
            #1;
            exp = (r <= nr) ? {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]} : 128'h0;
            check($sformatf("%s_rd%0d", tag, r), rdKey, exp);
        end
    endtask

    // Start an expansion, optionally disturb it, wait for done and check everything
    task automatic run_schedule(input string tag, input logic [1:0] len,
                                input logic [255:0] key, input bit disturb);
        int nk, nr, lat, n;
        nk  = (len == 2'b00) ? 4 : (len == 2'b01) ? 6 : 8;
        nr  = nk + 6;
        lat = 4 * (nr + 1) - nk;
        model_expand(nk, key);
        rdRound = 4'd0;
        do_start(len, key);
        check({tag, "_busy_start"}, busy, 1'b1);
        check({tag, "_valid_start"}, keyValid, 1'b0);
        check({tag, "_rd_expand"}, rdKey, 128'h0);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (disturb && n == 10) begin
                start  = 1'b1;
                keyLen = 2'($urandom_range(0, 2));
                keyIn  = {$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom};
            end
            if (disturb && n == 11) start = 1'b0;
        end while (!done && n < 300);
        check({tag, "_latency"}, n, lat);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_valid"}, keyValid, 1'b1);
        check({tag, "_nr"}, numRounds, nr);
        check({tag, "_busy_end"}, busy, 1'b0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, done, 1'b0);
        check_rounds(tag, nr);
    endtask

    initial begin
        logic [255:0] rkey;
        build_sbox();
        reset   = 1'b1;
        start   = 1'b0;
        keyLen  = 2'b00;
        keyIn   = '0;
        rdRound = 4'd0;
`ifdef AES_KEY_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_valid", keyValid, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_nr", numRounds, 4'd0);
        check("rst_rdkey", rdKey, 128'h0);
        reset = 1'b0;

        // FIPS-197 AES-128
        run_schedule("k128", 2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0);
        @(negedge clk); rdRound = 4'd1; #1;
        check("k128_vec_r1", rdKey, 128'ha0fafe1788542cb123a339392a6c7605);
        @(negedge clk); rdRound = 4'd10; #1;
        check("k128_vec_r10", rdKey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // FIPS-197 AES-192
        run_schedule("k192", 2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 1'b0);
        @(negedge clk); rdRound = 4'd12; #1;
        check("k192_vec_r12", rdKey, 128'he98ba06f448c773c8ecc720401002202);
        @(negedge clk); rdRound = 4'd13; #1;
        check("k192_vec_r13", rdKey, 128'h0);

        // FIPS-197 AES-256
        run_schedule("k256", 2'b10,
                     256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 1'b0);
        @(negedge clk); rdRound = 4'd14; #1;
        check("k256_vec_r14", rdKey, 128'hfe4890d1e6188d0b046df344706c631e);
        @(negedge clk); rdRound = 4'd15; #1;
        check("k256_vec_r15", rdKey, 128'h0);

        // Illegal key length invalidates the schedule and sets a sticky error
        rdRound = 4'd0;
        do_start(2'b11, '1);
        check("ill_error", error, 1'b1);
        check("ill_busy", busy, 1'b0);
        check("ill_valid", keyValid, 1'b0);
        check("ill_nr", numRounds, 4'd0);
        check("ill_rdkey", rdKey, 128'h0);
        repeat (3) @(negedge clk);
        check("ill_sticky", error, 1'b1);
        check("ill_still_idle", busy, 1'b0);
        run_schedule("after_ill", 2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0);
        check("ill_cleared", error, 1'b0);

        // Restart request and key changes during expansion are ignored
        run_schedule("disturb", 2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b1);
        @(negedge clk); rdRound = 4'd10; #1;
        check("disturb_vec_r10", rdKey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Reset in the middle of an AES-256 expansion
        rdRound = 4'd0;
        do_start(2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
        repeat (19) @(negedge clk);
        check("mid_busy", busy, 1'b1);
        check("mid_rdkey", rdKey, 128'h0);
        reset = 1'b1;
        @(negedge clk);
        check("mrst_busy", busy, 1'b0);
        check("mrst_done", done, 1'b0);
        check("mrst_valid", keyValid, 1'b0);
        check("mrst_error", error, 1'b0);
        check("mrst_nr", numRounds, 4'd0);
        check("mrst_rdkey", rdKey, 128'h0);
        reset = 1'b0;
        run_schedule("rerun256", 2'b10,
                     256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 1'b0);

        // Random keys of every length against the reference expansion
        for (int it = 0; it < 6; it++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
            run_schedule($sformatf("rnd%0d", it), 2'(it % 3), rkey, (it % 2) == 1);
        end

`ifdef AES_KEY_ZEROIZE_EN
        run_schedule("zpre", 2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0);
        @(negedge clk);
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        check("zero_valid", keyValid, 1'b0);
        check("zero_nr", numRounds, 4'd0);
        for (int i = 0; i < 60; i++) mw[i] = 32'h0;
        check_rounds("zero", -1);
        @(negedge clk);
        keyLen  = 2'b00;
        keyIn   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        start   = 1'b1;
        zeroize = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        zeroize = 1'b0;
        check("zero_start_busy", busy, 1'b0);
        check("zero_start_valid", keyValid, 1'b0);
        repeat (45) @(negedge clk);
        check("zero_start_never_done", keyValid, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
